// File: rtl/canon_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : canon_pkg
//  Purpose  : Shared types and tables for the canon sequencer: FSM state
//             encoding, melody ROM (6-bit notes, 0 = rest) and the pitch
//             LUT mapping a note number to a 12-bit player divider.
//  Revision : 1.0 - initial release
// ============================================================================
package canon_pkg;

  localparam int MELODY_MAX = 64;
  localparam logic [5:0] NOTE_REST = 6'd0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  // Note 34 is A4; 25 = C4. Rests are placed early so short songs exercise them.
  localparam logic [5:0] MELODY [MELODY_MAX] = '{
    6'd25, 6'd29, 6'd0,  6'd32, 6'd25, 6'd27, 6'd29, 6'd25,
    6'd25, 6'd27, 6'd29, 6'd25, 6'd29, 6'd30, 6'd32, 6'd0,
    6'd29, 6'd30, 6'd32, 6'd0,  6'd32, 6'd34, 6'd32, 6'd30,
    6'd29, 6'd25, 6'd32, 6'd34, 6'd32, 6'd30, 6'd29, 6'd25,
    6'd25, 6'd20, 6'd25, 6'd0,  6'd25, 6'd20, 6'd25, 6'd0,
    6'd37, 6'd36, 6'd34, 6'd32, 6'd30, 6'd29, 6'd27, 6'd25,
    6'd27, 6'd29, 6'd30, 6'd32, 6'd34, 6'd36, 6'd37, 6'd0,
    6'd37, 6'd32, 6'd29, 6'd25, 6'd20, 6'd25, 6'd0,  6'd0
  };

  // round(50e6 / (256 * 440 * 2^((n-34)/12))) - 1; entry 0 is never used.
  localparam logic [11:0] PITCH [MELODY_MAX] = '{
    12'd0,    12'd2985, 12'd2818, 12'd2659, 12'd2510, 12'd2369, 12'd2236, 12'd2111,
    12'd1992, 12'd1880, 12'd1775, 12'd1675, 12'd1581, 12'd1492, 12'd1408, 12'd1329,
    12'd1255, 12'd1184, 12'd1118, 12'd1055, 12'd996,  12'd940,  12'd887,  12'd837,
    12'd790,  12'd746,  12'd704,  12'd664,  12'd627,  12'd592,  12'd558,  12'd527,
    12'd497,  12'd469,  12'd443,  12'd418,  12'd394,  12'd372,  12'd351,  12'd332,
    12'd313,  12'd295,  12'd279,  12'd263,  12'd248,  12'd234,  12'd221,  12'd208,
    12'd197,  12'd186,  12'd175,  12'd165,  12'd156,  12'd147,  12'd139,  12'd131,
    12'd124,  12'd117,  12'd110,  12'd104,  12'd98,   12'd92,   12'd87,   12'd82
  };

  function automatic logic [5:0] melody_rom(input logic [5:0] idx);
    return MELODY[idx];
  endfunction

  function automatic logic [11:0] pitch_lut(input logic [5:0] note);
    return PITCH[note];
  endfunction

endpackage
`default_nettype wire

// File: rtl/canon_beat_timer.sv
`default_nettype none
// ============================================================================
//  Module   : canon_beat_timer
//  Purpose  : Beat down-counter with self-reload on zero, plus a registered
//             one-cycle beat pulse requested by the sequencer FSM.
//  Revision : 1.0 - initial release
// ============================================================================
module canon_beat_timer #(
  parameter int BEAT_DIV = 6250000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,    // preload BEAT_DIV-1 (playback start)
  input  logic clear,   // force counter to 0 (stop)
  input  logic run,     // count down, reload when reaching 0
  input  logic fire,    // emit a beat pulse next cycle
  output logic zero,
  output logic beat
);

  localparam int CW = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(BEAT_DIV - 1);

  logic [CW-1:0] count;

  // Counter priority: clear over load over free-running decrement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      beat  <= 1'b0;
    end else begin
      beat <= fire;
      if (clear)
        count <= '0;
      else if (load)
        count <= RELOAD;
      else if (run)
        count <= (count == '0) ? RELOAD : count - CW'(1);
    end
  end

  assign zero = (count == '0);

endmodule
`default_nettype wire

// File: rtl/canon_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : canon_sequencer
//  Purpose  : Four-voice round sequencer. Each beat, one melody/pitch lookup
//             is time-multiplexed across the voices (one voice per cycle);
//             voice v plays the melody delayed by v*OFFSET_BEATS beats.
//  Revision : 1.0 - initial release
// ============================================================================
module canon_sequencer
  import canon_pkg::*;
#(
  parameter int BEAT_DIV     = 6250000,
  parameter int SONG_LEN     = 64,
  parameter int OFFSET_BEATS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        loop_en,
  output logic [11:0] divider1,
  output logic [11:0] divider2,
  output logic [11:0] divider3,
  output logic [11:0] divider4,
  output logic [3:0]  gate,
  output logic        playing,
  output logic        beat
);

  localparam logic [7:0] END_G = 8'(SONG_LEN + 3 * OFFSET_BEATS);
  localparam logic [9:0] LEN_W = 10'(SONG_LEN);
  localparam logic [9:0] OFF_W = 10'(OFFSET_BEATS);

  state_t      state, state_nxt;
  logic [7:0]  g, g_nxt;
  logic [1:0]  vidx, vidx_nxt;
  logic        play_nxt;
  logic        t_load, t_clear, t_run, t_fire, t_zero;
  logic        voice_upd, clr_gate;
  logic [9:0]  s_off, rel;
  logic        voice_live;
  logic [5:0]  note;
  logic [11:0] div_q [4];

  canon_beat_timer #(.BEAT_DIV(BEAT_DIV)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (t_load),
    .clear (t_clear),
    .run   (t_run),
    .fire  (t_fire),
    .zero  (t_zero),
    .beat  (beat)
  );

  // Melody position of the voice currently being serviced.
  always_comb begin
    s_off      = 10'(vidx) * OFF_W;
    rel        = {2'b00, g} - s_off;
    voice_live = ({2'b00, g} >= s_off) && (rel < LEN_W);
    note       = melody_rom(rel[5:0]);
  end

  // Next-state logic and control strobes; stop overrides everything outside IDLE.
  always_comb begin
    state_nxt = state;
    g_nxt     = g;
    vidx_nxt  = vidx;
    play_nxt  = playing;
    t_load    = 1'b0;
    t_clear   = 1'b0;
    t_run     = 1'b0;
    t_fire    = 1'b0;
    voice_upd = 1'b0;
    clr_gate  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !stop) begin
          state_nxt = ST_UPDATE;
          g_nxt     = 8'd0;
          vidx_nxt  = 2'd0;
          play_nxt  = 1'b1;
          t_load    = 1'b1;
          t_fire    = 1'b1;
        end
      end
      ST_UPDATE: begin
        t_run     = 1'b1;
        voice_upd = 1'b1;
        vidx_nxt  = vidx + 2'd1;
        if (vidx == 2'd3)
          state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        t_run = 1'b1;
        if (t_zero) begin
          vidx_nxt = 2'd0;
          if ((g + 8'd1) == END_G && !loop_en) begin
            state_nxt = ST_IDLE;
            g_nxt     = g + 8'd1;
            play_nxt  = 1'b0;
            clr_gate  = 1'b1;
          end else begin
            state_nxt = ST_UPDATE;
            g_nxt     = ((g + 8'd1) == END_G) ? 8'd0 : g + 8'd1;
            t_fire    = 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (stop && state != ST_IDLE) begin
      state_nxt = ST_IDLE;
      g_nxt     = 8'd0;
      vidx_nxt  = 2'd0;
      play_nxt  = 1'b0;
      t_clear   = 1'b1;
      t_run     = 1'b0;
      t_fire    = 1'b0;
      voice_upd = 1'b0;
      clr_gate  = 1'b1;
    end
  end

  // FSM and sequencing registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      g       <= 8'd0;
      vidx    <= 2'd0;
      playing <= 1'b0;
    end else begin
      state   <= state_nxt;
      g       <= g_nxt;
      vidx    <= vidx_nxt;
      playing <= play_nxt;
    end
  end

  // Per-voice output registers; rests and inactive voices keep their divider.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gate <= 4'b0000;
      for (int i = 0; i < 4; i++) div_q[i] <= 12'd0;
    end else if (clr_gate) begin
      gate <= 4'b0000;
    end else if (voice_upd) begin
      if (voice_live && note != NOTE_REST) begin
        div_q[vidx] <= pitch_lut(note);
        gate[vidx]  <= 1'b1;
      end else begin
        gate[vidx]  <= 1'b0;
      end
    end
  end

  assign divider1 = div_q[0];
  assign divider2 = div_q[1];
  assign divider3 = div_q[2];
  assign divider4 = div_q[3];

endmodule
`default_nettype wire

// File: tb/tb_canon_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_canon_sequencer
//  Purpose  : Directed bench for canon_sequencer with BEAT_DIV=8,
//             SONG_LEN=4, OFFSET_BEATS=2 (END = 10). Melody notes 0..3 are
//             25, 29, rest, 32 -> dividers 746, 592, held, 497.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_canon_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop_en = 1'b0;
  logic [11:0] divider1, divider2, divider3, divider4;
  logic [3:0]  gate;
  logic        playing, beat;

  int vectors = 0;
  int miscompares = 0;

  canon_sequencer #(.BEAT_DIV(8), .SONG_LEN(4), .OFFSET_BEATS(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .loop_en  (loop_en),
    .divider1 (divider1),
    .divider2 (divider2),
    .divider3 (divider3),
    .divider4 (divider4),
    .gate     (gate),
    .playing  (playing),
    .beat     (beat)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n active edges, leaving time 1 unit after the last edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // Asynchronous reset before any clock edge.
    #2 rst = 1'b1;
    #1;
    check_vec("rst_div1", divider1, 0);
    check_vec("rst_div4", divider4, 0);
    check_vec("rst_gate", gate, 0);
    check_vec("rst_playing", playing, 0);
    check_vec("rst_beat", beat, 0);
    tick(2);
    rst = 1'b0;
    tick(1);
    check_vec("idle_playing", playing, 0);

    // Run 1: no loop, full song to END.
    loop_en = 1'b0;
    start = 1'b1;
    tick(1);                       // E0
    start = 1'b0;
    check_vec("r1_e0_beat", beat, 1);
    check_vec("r1_e0_playing", playing, 1);
    check_vec("r1_e0_gate", gate, 0);
    tick(1);                       // E1
    check_vec("r1_e1_beat", beat, 0);
    check_vec("r1_e1_div1", divider1, 746);
    check_vec("r1_e1_gate", gate, 4'b0001);
    tick(6);                       // E7
    check_vec("r1_e7_beat", beat, 0);
    tick(1);                       // E8
    check_vec("r1_e8_beat", beat, 1);
    tick(9);                       // E17: voice 0 on a rest
    check_vec("r1_rest_gate", gate, 4'b0000);
    check_vec("r1_rest_div1", divider1, 592);
    tick(1);                       // E18: voice 1 enters
    check_vec("r1_v1_gate", gate, 4'b0010);
    check_vec("r1_v1_div2", divider2, 746);
    tick(17);                      // E35: voice 2 enters
    check_vec("r1_v2_gate", gate, 4'b0100);
    check_vec("r1_v2_div3", divider3, 746);
    tick(16);                      // E51: voice 3 not yet written
    check_vec("r1_e51_gate", gate, 4'b0000);
    check_vec("r1_e51_div4", divider4, 0);
    tick(1);                       // E52: voice 3, 4 cycles after beat
    check_vec("r1_v3_div4", divider4, 746);
    check_vec("r1_v3_gate", gate, 4'b1000);
    tick(27);                      // E79: last beat still playing
    check_vec("r1_e79_playing", playing, 1);
    check_vec("r1_e79_gate", gate, 4'b1000);
    tick(1);                       // E80: END reached
    check_vec("r1_end_playing", playing, 0);
    check_vec("r1_end_gate", gate, 0);
    check_vec("r1_end_beat", beat, 0);
    check_vec("r1_end_div4", divider4, 497);
    check_vec("r1_end_div1", divider1, 497);
    tick(8);
    check_vec("r1_idle_playing", playing, 0);
    check_vec("r1_idle_beat", beat, 0);

    // Run 2: loop at END, then stop in UPDATE cycle 2.
    loop_en = 1'b1;
    start = 1'b1;
    tick(1);                       // E0
    start = 1'b0;
    check_vec("r2_e0_beat", beat, 1);
    tick(80);                      // E80: wrap
    check_vec("r2_wrap_beat", beat, 1);
    check_vec("r2_wrap_playing", playing, 1);
    tick(1);                       // E81
    check_vec("r2_wrap_div1", divider1, 746);
    check_vec("r2_wrap_gate", gate, 4'b1001);
    tick(1);                       // E82
    check_vec("r2_e82_gate", gate, 4'b1001);
    stop = 1'b1;
    tick(1);                       // E83
    stop = 1'b0;
    check_vec("stop_playing", playing, 0);
    check_vec("stop_gate", gate, 0);
    check_vec("stop_div1", divider1, 746);
    check_vec("stop_div4", divider4, 497);
    tick(10);
    check_vec("stop_idle_playing", playing, 0);
    check_vec("stop_idle_beat", beat, 0);

    // stop and start together from IDLE: stop wins.
    start = 1'b1;
    stop = 1'b1;
    tick(1);
    start = 1'b0;
    stop = 1'b0;
    check_vec("ss_playing", playing, 0);
    check_vec("ss_beat", beat, 0);
    tick(9);
    check_vec("ss_idle_playing", playing, 0);

    // start while playing is ignored.
    loop_en = 1'b0;
    start = 1'b1;
    tick(1);                       // E0
    start = 1'b0;
    tick(3);                       // E3
    start = 1'b1;
    tick(1);                       // E4
    start = 1'b0;
    check_vec("restart_beat", beat, 0);
    check_vec("restart_playing", playing, 1);
    tick(4);                       // E8
    check_vec("restart_e8_beat", beat, 1);
    tick(1);                       // E9: g = 1
    check_vec("restart_div1", divider1, 592);
    check_vec("restart_gate", gate, 4'b0001);

    // Asynchronous reset in the middle of UPDATE.
    #3 rst = 1'b1;
    #1;
    check_vec("arst_playing", playing, 0);
    check_vec("arst_gate", gate, 0);
    check_vec("arst_div1", divider1, 0);
    check_vec("arst_beat", beat, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick(3);
    check_vec("arst_idle_playing", playing, 0);
    check_vec("arst_idle_div1", divider1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
